// File: rtl/edge_arb_pkg.sv
// Shared types and sizing helpers for the edge event arbiter and its round-robin grant logic.
package edge_arb_pkg;

    typedef enum logic {
        EDGE_FALLING = 1'b0,
        EDGE_RISING  = 1'b1
    } edge_type_e;

    localparam int MAX_NUM_CH = 16;

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a down-counter that must hold max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

    function automatic bit num_ch_legal(input int n);
        return (n >= 2) && (n <= MAX_NUM_CH);
    endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Valid/ready event port: the arbiter drives valid and channel index, the consumer drives ready.
interface edge_event_arbiter_if #(
    parameter int NUM_CH = 4
) ();

    logic                                     evt_valid;
    logic                                     evt_ready;
    logic [edge_arb_pkg::ch_width(NUM_CH)-1:0] evt_ch;

    modport master (
        output evt_valid,
        output evt_ch,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_ch,
        output evt_ready
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin grant selection: picks the first request at or after the pointer, wrapping,
// and moves the pointer just past the winner whenever the grant is taken.
module rr_arbiter
    import edge_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int CW    = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [CW-1:0]     grant_idx,
    output logic              any_req
);

    logic [CW-1:0] ptr_q;
    logic [CW-1:0] ptr_d;
    logic [CW-1:0] idx;
    logic          found;

    assign any_req = |req;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = CW'((int'(ptr_q) + i) % NUM_CH);
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (grant_idx == CW'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event collector: edge detect, per-channel hold-off, pending latch,
// round-robin serialisation onto one valid/ready port. Optional input synchroniser: EDGE_EVENT_ARBITER_SYNC_EN.
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int EDGE_TYPE      = 1,
    parameter int HOLDOFF_CYCLES = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          signal_in,
    input  logic [NUM_CH-1:0]          ch_enable,
    edge_event_arbiter_if.master       evt_if,
    output logic [NUM_CH-1:0]          overflow,
    input  logic [NUM_CH-1:0]          clr_overflow
);

    localparam int            CW        = ch_width(NUM_CH);
    localparam int            HW        = cnt_width(HOLDOFF_CYCLES);
    localparam logic          ASSERTED  = (EDGE_TYPE == int'(EDGE_RISING));
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES);

    logic [NUM_CH-1:0] sig_s;
    logic [NUM_CH-1:0] prev_q;
    logic [NUM_CH-1:0] edge_hit;
    logic [NUM_CH-1:0] hold_zero;
    logic [NUM_CH-1:0] accept;
    logic [NUM_CH-1:0] pending_q,  pending_d;
    logic [NUM_CH-1:0] overflow_q, overflow_d;
    logic [NUM_CH-1:0] grant_oh;
    logic [HW-1:0]     hold_q [NUM_CH];
    logic [HW-1:0]     hold_d [NUM_CH];
    logic              valid_q, valid_d;
    logic [CW-1:0]     ch_q,    ch_d;
    logic [CW-1:0]     grant_idx;
    logic              any_req;
    logic              load;

`ifdef EDGE_EVENT_ARBITER_SYNC_EN
    logic [NUM_CH-1:0] sync1_q, sync2_q;

    // Synchroniser idles at the asserted level so reset release never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= {NUM_CH{ASSERTED}};
            sync2_q <= {NUM_CH{ASSERTED}};
        end else begin
            sync1_q <= signal_in;
            sync2_q <= sync1_q;
        end
    end

    assign sig_s = sync2_q;
`else
    assign sig_s = signal_in;
`endif

    assign edge_hit = ASSERTED ? (sig_s & ~prev_q) : (~sig_s & prev_q);

    always_comb begin
        hold_zero = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hold_zero[i] = (hold_q[i] == '0);
        end
    end

    assign accept = edge_hit & ch_enable & hold_zero;

    rr_arbiter #(
        .NUM_CH    (NUM_CH)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst       (rst),
        .req       (pending_q),
        .advance   (load),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    assign load = any_req && (!valid_q || evt_if.evt_ready);

    always_comb begin
        grant_oh            = '0;
        grant_oh[grant_idx] = load;
    end

    // A fresh edge on the channel being granted re-arms pending without counting as overflow.
    assign pending_d  = ((pending_q & ~grant_oh) | accept) & ch_enable;
    assign overflow_d = (overflow_q & ~clr_overflow) | (accept & pending_q & ~grant_oh);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            hold_d[i] = hold_q[i];
            if (accept[i]) begin
                hold_d[i] = HOLD_LOAD;
            end else if (!hold_zero[i]) begin
                hold_d[i] = hold_q[i] - 1'b1;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        ch_d    = ch_q;
        if (load) begin
            valid_d = 1'b1;
            ch_d    = grant_idx;
        end else if (valid_q && evt_if.evt_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q     <= {NUM_CH{ASSERTED}};
            pending_q  <= '0;
            overflow_q <= '0;
            valid_q    <= 1'b0;
            ch_q       <= '0;
            // NOTE: the hold-off array is a bank of flops, not RAM, so it is safe to reset element by element.
            for (int i = 0; i < NUM_CH; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            prev_q     <= sig_s;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            ch_q       <= ch_d;
            for (int i = 0; i < NUM_CH; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign evt_if.evt_valid = valid_q;
    assign evt_if.evt_ch    = ch_q;
    assign overflow         = overflow_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench: two arbiters (hold-off 0 and 5) share stimulus and are compared every
// cycle against a behavioural model, with directed scenarios followed by random traffic.
module tb_edge_event_arbiter;
    import edge_arb_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] sig, en, clr;
    logic         ready;

    always #5 clk = ~clk;

    edge_event_arbiter_if #(.NUM_CH(N)) if0 ();
    edge_event_arbiter_if #(.NUM_CH(N)) if5 ();
    assign if0.evt_ready = ready;
    assign if5.evt_ready = ready;

    logic [N-1:0] ov0, ov5;

    edge_event_arbiter #(.NUM_CH(N), .EDGE_TYPE(1), .HOLDOFF_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .signal_in(sig), .ch_enable(en),
        .evt_if(if0), .overflow(ov0), .clr_overflow(clr)
    );

    edge_event_arbiter #(.NUM_CH(N), .EDGE_TYPE(1), .HOLDOFF_CYCLES(5)) dut5 (
        .clk(clk), .rst(rst), .signal_in(sig), .ch_enable(en),
        .evt_if(if5), .overflow(ov5), .clr_overflow(clr)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int       hold_cfg [2] = '{0, 5};
    bit [N-1:0] m_prev [2];
    bit [N-1:0] m_pend [2];
    bit [N-1:0] m_ov   [2];
    int       m_hold [2][N];
    int       m_ptr  [2];
    bit       m_valid[2];
    int       m_ch   [2];
    bit       started = 1'b0;

    task automatic model_step(input int m);
        bit [N-1:0] acc;
        bit         fire;
        int         win;
        if (rst) begin
            m_prev[m]  = '1;
            m_pend[m]  = '0;
            m_ov[m]    = '0;
            m_ptr[m]   = 0;
            m_valid[m] = 1'b0;
            m_ch[m]    = 0;
            for (int i = 0; i < N; i++) m_hold[m][i] = 0;
            return;
        end
        acc = '0;
        for (int i = 0; i < N; i++)
            acc[i] = en[i] && sig[i] && !m_prev[m][i] && (m_hold[m][i] == 0);
        fire = (m_pend[m] != '0) && (!m_valid[m] || ready);
        win  = -1;
        if (fire) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr[m] + k) % N;
                if (win < 0 && m_pend[m][c]) win = c;
            end
        end
        for (int i = 0; i < N; i++) begin
            bit granted;
            granted = fire && (i == win);
            if (acc[i] && m_pend[m][i] && !granted) m_ov[m][i] = 1'b1;
            else if (clr[i])                        m_ov[m][i] = 1'b0;
            m_pend[m][i] = ((m_pend[m][i] && !granted) || acc[i]) && en[i];
            if (acc[i])                m_hold[m][i] = hold_cfg[m];
            else if (m_hold[m][i] > 0) m_hold[m][i] = m_hold[m][i] - 1;
            m_prev[m][i] = sig[i];
        end
        if (fire) begin
            m_valid[m] = 1'b1;
            m_ch[m]    = win;
            m_ptr[m]   = (win + 1) % N;
        end else if (m_valid[m] && ready) begin
            m_valid[m] = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        started <= 1'b1;
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (started) begin
            check("h0 evt_valid", 32'(if0.evt_valid), 32'(m_valid[0]));
            check("h0 evt_ch",    32'(if0.evt_ch),    32'(m_ch[0]));
            check("h0 overflow",  32'(ov0),           32'(m_ov[0]));
            check("h5 evt_valid", 32'(if5.evt_valid), 32'(m_valid[1]));
            check("h5 evt_ch",    32'(if5.evt_ch),    32'(m_ch[1]));
            check("h5 overflow",  32'(ov5),           32'(m_ov[1]));
        end
    end

    // ---------------- delivered-event monitor ----------------
    int ev_cnt [2][N];
    int seq [$];
    bit rec = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            if (if0.evt_valid && ready) begin
                ev_cnt[0][if0.evt_ch] = ev_cnt[0][if0.evt_ch] + 1;
                if (rec) seq.push_back(int'(if0.evt_ch));
            end
            if (if5.evt_valid && ready) ev_cnt[1][if5.evt_ch] = ev_cnt[1][if5.evt_ch] + 1;
        end
    end

    task automatic clear_counts();
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < N; i++) ev_cnt[m][i] = 0;
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n0, n3;
        rst = 1'b1; sig = 4'b0001; en = '1; clr = '0; ready = 1'b0;
        clear_counts();
        repeat (2) cyc();
        check("reset evt_valid", 32'(if0.evt_valid), 0);
        check("reset overflow",  32'(ov0), 0);
        rst = 1'b0;
        repeat (3) cyc();
        check("held-high no event", 32'(m_valid[0]), 0);

        // first edge after reset: valid two edges after sampled rise
        sig[0] = 1'b0; cyc();
        sig[0] = 1'b1; cyc();
        check("latency edge1 valid", 32'(m_valid[0]), 0);
        cyc();
        check("latency edge2 valid", 32'(m_valid[0]), 1);
        check("latency edge2 ch",    32'(m_ch[0]), 0);
        ready = 1'b1; cyc();
        check("handshake drops valid", 32'(m_valid[0]), 0);

        // simultaneous edges on 1,2,3 drained in RR order
        sig = '0; cyc();
        sig = 4'b1110; cyc();
        cyc(); check("rr first",  32'(m_ch[0]), 1);
        cyc(); check("rr second", 32'(m_ch[0]), 2);
        cyc(); check("rr third",  32'(m_ch[0]), 3);
        cyc(); check("rr drained", 32'(m_valid[0]), 0);

        // overflow on ch 2 while blocked
        sig = '0; ready = 1'b0; clear_counts(); cyc();
        sig = 4'b0110; cyc();
        sig = '0; cyc();
        check("blocked holds ch1", 32'(m_ch[0]), 1);
        sig = 4'b0100; cyc();
        check("overflow set", 32'(m_ov[0][2]), 1);
        sig = '0; cyc();
        ready = 1'b1; cyc();
        check("merged ch2 out", 32'(m_ch[0]), 2);
        cyc();
        check("after merge idle", 32'(m_valid[0]), 0);
        check("one ch2 event", 32'(ev_cnt[0][2]), 1);
        clr = 4'b0100; cyc(); clr = '0;
        check("overflow cleared", 32'(m_ov[0][2]), 0);

        // set and clear collide: set wins
        ready = 1'b0; sig = 4'b0110; cyc();
        sig = '0; cyc();
        check("rr from ptr3 picks 1", 32'(m_ch[0]), 1);
        sig = 4'b0100; clr = 4'b0100; cyc();
        check("set beats clr", 32'(m_ov[0][2]), 1);
        check("set beats clr dut", 32'(ov0[2]), 1);
        sig = '0; clr = '0; ready = 1'b1; cyc(); cyc();
        clr = '1; cyc(); clr = '0;

        // hold-off window of 5
        repeat (8) cyc();
        clear_counts();
        for (int j = 0; j < 8; j++) begin
            sig[0] = (j == 0 || j == 3 || j == 6);
            cyc();
        end
        sig = '0; repeat (4) cyc();
        check("holdoff0 three events", 32'(ev_cnt[0][0]), 3);
        check("holdoff5 two events",   32'(ev_cnt[1][0]), 2);
        check("holdoff5 no overflow",  32'(ov5[0]), 0);

        // continuous traffic on ch 0 and 3: no starvation
        clear_counts(); seq.delete(); rec = 1'b1;
        for (int j = 0; j < 16; j++) begin
            sig = (j % 2 == 0) ? 4'b1001 : 4'b0000;
            cyc();
        end
        sig = '0; repeat (3) cyc(); rec = 1'b0;
        check("alt ch0 count", 32'(ev_cnt[0][0]), 8);
        check("alt ch3 count", 32'(ev_cnt[0][3]), 8);
        check("alt no overflow", 32'(ov0), 0);
        for (int k = 1; k < seq.size(); k++)
            check("grants alternate", 32'(seq[k] == seq[k-1]), 0);

        // disable ch 3 mid-run
        en = 4'b0111;
        for (int j = 0; j < 14; j++) begin
            if (j == 2) clear_counts();
            sig = (j % 2 == 0) ? 4'b1001 : 4'b0000;
            cyc();
        end
        sig = '0; repeat (3) cyc();
        check("disabled ch3 silent", 32'(ev_cnt[0][3]), 0);
        check("ch0 still served", 32'(ev_cnt[0][0] > 0), 1);
        check("ch3 pending cleared", 32'(m_pend[0][3]), 0);
        en = '1;

        // reset with output full and three pending
        ready = 1'b0; cyc();
        sig = 4'b1111; cyc(); cyc();
        check("pre-reset valid", 32'(m_valid[0]), 1);
        n0 = 0;
        for (int i = 0; i < N; i++) n0 += int'(m_pend[0][i]);
        check("pre-reset pending", 32'(n0), 3);
        rst = 1'b1; cyc(); rst = 1'b0;
        check("reset flushes valid", 32'(m_valid[0]), 0);
        ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            cyc();
            check("quiet after reset", 32'(if0.evt_valid), 0);
        end
        sig = '0; cyc();

        // random traffic
        clear_counts();
        for (int j = 0; j < 3000; j++) begin
            rst   = ($urandom_range(0, 299) == 0);
            sig   = N'($urandom);
            en    = '1;
            for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) en[i] = 1'b0;
            ready = ($urandom_range(0, 3) != 0);
            clr   = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
            cyc();
        end
        rst = 1'b0; sig = '0; clr = '0; ready = 1'b1;
        repeat (6) cyc();
        n3 = 0;
        for (int i = 0; i < N; i++) n3 += ev_cnt[0][i];
        check("random traffic delivered", 32'(n3 > 0), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
